host_frame_ctrl: RTL

HOST_FRAME_CTRL -- requirements
Module: host_frame_ctrl

---
 rtl/host_frame_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/host_frame_ctrl.sv
// Host-side frame controller: collects an SPI frame into the input RAM, hands both
// RAMs to the engine, then streams the result count and result words back out over SPI.
module host_frame_ctrl #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] BUSY_WORD = '1,
  parameter logic [DATA_WIDTH-1:0] ERR_WORD  = DATA_WIDTH'(32'hBADC0DE0)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_done,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      in_en,
  output logic [DATA_WIDTH/8-1:0]   in_we,
  output logic [ADDR_WIDTH-1:0]     in_addr,
  output logic [DATA_WIDTH-1:0]     in_din,
  output logic                      out_en,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  input  logic [DATA_WIDTH-1:0]     out_dout,
  output logic                      eng_start,
  input  logic                      eng_busy,
  input  logic [DATA_WIDTH-1:0]     eng_count,
  output logic                      eng_own,
  output logic                      error,
  output logic [15:0]               frame_cnt
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [PW-1:0]         MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_FRAME = DATA_WIDTH'(MAX_WORDS);

  typedef enum logic [2:0] {HDR, LOAD, START, WAIT, SEND, ERR} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    rx_prev_q, rx_prev_d;
  logic [PW-1:0]           n_q, n_d, m_q, m_d;
  logic [PW-1:0]           load_ptr_q, load_ptr_d, send_ptr_q, send_ptr_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic                    in_en_q, in_en_d;
  logic [BW-1:0]           in_we_q, in_we_d;
  logic [ADDR_WIDTH-1:0]   in_addr_q, in_addr_d;
  logic [DATA_WIDTH-1:0]   in_din_q, in_din_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    rx_stb;

  // One strobe per synchronised rising edge, so a held level counts once.
  assign rx_stb = sync_q[SYNC_STAGES-1] & ~rx_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR;
      sync_q      <= '0;
      rx_prev_q   <= 1'b0;
      n_q         <= '0;
      m_q         <= '0;
      load_ptr_q  <= '0;
      send_ptr_q  <= '0;
      tx_q        <= '0;
      in_en_q     <= 1'b0;
      in_we_q     <= '0;
      in_addr_q   <= '0;
      in_din_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      n_q         <= n_d;
      m_q         <= m_d;
      load_ptr_q  <= load_ptr_d;
      send_ptr_q  <= send_ptr_d;
      tx_q        <= tx_d;
      in_en_q     <= in_en_d;
      in_we_q     <= in_we_d;
      in_addr_q   <= in_addr_d;
      in_din_q    <= in_din_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_done};
    rx_prev_d   = sync_q[SYNC_STAGES-1];
    n_d         = n_q;
    m_d         = m_q;
    load_ptr_d  = load_ptr_q;
    send_ptr_d  = send_ptr_q;
    tx_d        = tx_q;
    in_en_d     = 1'b0;
    in_we_d     = '0;
    in_addr_d   = in_addr_q;
    in_din_d    = in_din_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      HDR: begin
        if (rx_stb) begin
          load_ptr_d = '0;
          if (rx_data != '0 && rx_data <= MAX_FRAME) begin
            n_d     = rx_data[PW-1:0];
            tx_d    = BUSY_WORD;
            state_d = LOAD;
          end else begin
            tx_d    = ERR_WORD;
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        // The last write pulse has already left the register when the pointer reaches N.
        if (load_ptr_q == n_q) begin
          state_d = START;
        end else if (rx_stb) begin
          in_en_d    = 1'b1;
          in_we_d    = '1;
          in_addr_d  = load_ptr_q[ADDR_WIDTH-1:0];
          in_din_d   = rx_data;
          load_ptr_d = load_ptr_q + 1'b1;
        end
      end
      START: begin
        if (eng_busy) state_d = WAIT;
      end
      WAIT: begin
        if (!eng_busy) begin
          if (eng_count > MAX_FRAME) begin
            tx_d    = ERR_WORD;
            state_d = ERR;
          end else begin
            m_d        = eng_count[PW-1:0];
            tx_d       = eng_count;
            send_ptr_d = '0;
            state_d    = SEND;
          end
        end
      end
      SEND: begin
        if (rx_stb) begin
          if (send_ptr_q < m_q) begin
            tx_d       = out_dout;
            send_ptr_d = send_ptr_q + 1'b1;
          end else begin
            tx_d        = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = HDR;
          end
        end
      end
      ERR: begin
        tx_d = ERR_WORD;
      end
      default: state_d = HDR;
    endcase
  end

  assign tx_data   = tx_q;
  assign in_en     = in_en_q;
  assign in_we     = in_we_q;
  assign in_addr   = in_addr_q;
  assign in_din    = in_din_q;
  assign out_en    = (state_q == SEND);
  assign out_addr  = send_ptr_q[ADDR_WIDTH-1:0];
  assign eng_start = (state_q == START);
  assign eng_own   = (state_q == START) || (state_q == WAIT);
  assign error     = (state_q == ERR);
  assign frame_cnt = frame_cnt_q;

endmodule
